// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - field-set handshake and instruction-memory write port of inst_encoder
//
// master: field source (drives in_*, observes in_ready and the write port)
// slave : encoder (accepts in_*, drives in_ready, mem_we, mem_addr, mem_wdata)
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [4:0]        in_opcode;
    logic [2:0]        in_rd;
    logic [2:0]        in_rs;
    logic [7:0]        in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs instruction fields into 16-bit words and writes them to instruction memory
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, base_addr    begin a program load at base_addr (ignored while loading)
//   bus                 inst_encoder_if.slave: field handshake in, memory write port out
//   busy, done          loading / one-cycle completion pulse
//   err, err_code       sticky error: 1=illegal fmt, 2=I5 imm too wide, 3=overflow
//   word_count          words written since start
//   checksum            XOR of written words when INST_ENC_CHECKSUM_EN is defined, else 0
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    inst_encoder_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       checksum
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    // word_count value at which memory is full
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [15:0]       enc_word;
    logic [1:0]        fault;
    logic              hs;

    // in_ready is registered and is high exactly in RUN
    assign hs = bus.in_valid & bus.in_ready;

    always_comb begin
        enc_word = 16'h0000;
        case (bus.in_fmt)
            2'd0:    enc_word = {5'b0, bus.in_rs, bus.in_rd, bus.in_opcode};
            2'd1:    enc_word = {bus.in_imm[4:0], bus.in_rs, bus.in_rd, bus.in_opcode};
            2'd2:    enc_word = {bus.in_imm, bus.in_rd, bus.in_opcode};
            default: enc_word = 16'h0000;
        endcase

        fault = 2'd0;
        if (bus.in_fmt == 2'd3)
            fault = 2'd1;
        else if (bus.in_fmt == 2'd1 && bus.in_imm[7:5] != 3'b000)
            fault = 2'd2;
        else if (word_count == FULL)
            fault = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'd0;
            word_count    <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            done       <= 1'b0;
            case (state)
                RUN: begin
                    if (hs) begin
                        if (fault != 2'd0) begin
                            state        <= ERR;
                            err          <= 1'b1;
                            err_code     <= fault;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= ptr;
                            bus.mem_wdata <= enc_word;
                            ptr           <= ptr + ADDR_W'(1);
                            word_count    <= word_count + 1'b1;
                            if (bus.in_last) begin
                                state        <= DONE;
                                done         <= 1'b1;
                                bus.in_ready <= 1'b0;
                                busy         <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all honour start
                    if (start) begin
                        state        <= RUN;
                        ptr          <= base_addr;
                        word_count   <= '0;
                        err          <= 1'b0;
                        err_code     <= 2'd0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef INST_ENC_CHECKSUM_EN
    logic [15:0] chk_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            chk_q <= 16'h0000;
        else if (start && state != RUN)
            chk_q <= 16'h0000;
        else if (state == RUN && hs && fault == 2'd0)
            chk_q <= chk_q ^ enc_word;
    end

    assign checksum = chk_q;
`else
    assign checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder (ADDR_W=8 and ADDR_W=2 instances)
module tb_inst_encoder;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, in_valid, in_last;
    logic [7:0] base_addr, in_imm;
    logic [1:0] in_fmt;
    logic [4:0] in_opcode;
    logic [2:0] in_rd, in_rs;

    inst_encoder_if #(.ADDR_W(8)) bus8 ();
    inst_encoder_if #(.ADDR_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;  assign bus2.in_valid  = in_valid;
    assign bus8.in_fmt    = in_fmt;    assign bus2.in_fmt    = in_fmt;
    assign bus8.in_opcode = in_opcode; assign bus2.in_opcode = in_opcode;
    assign bus8.in_rd     = in_rd;     assign bus2.in_rd     = in_rd;
    assign bus8.in_rs     = in_rs;     assign bus2.in_rs     = in_rs;
    assign bus8.in_imm    = in_imm;    assign bus2.in_imm    = in_imm;
    assign bus8.in_last   = in_last;   assign bus2.in_last   = in_last;

    logic        busy8, done8, err8, busy2, done2, err2;
    logic [1:0]  code8, code2;
    logic [8:0]  wc8;
    logic [2:0]  wc2;
    logic [15:0] cs8, cs2;

    inst_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus8),
        .busy(busy8), .done(done8), .err(err8), .err_code(code8), .word_count(wc8), .checksum(cs8)
    );

    inst_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr[1:0]), .bus(bus2),
        .busy(busy2), .done(done2), .err(err2), .err_code(code2), .word_count(wc2), .checksum(cs2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state, one entry per instance
    int aw[2] = '{8, 2};
    int m_mode[2], m_ptr[2], m_cnt[2], m_err[2], m_code[2], m_done[2];
    int m_we[2], m_addr[2], m_wdata[2], m_chk[2];

    function automatic int encode(int fmt, int op, int rd, int rs, int imm);
        case (fmt)
            0:       return rs * 256 + rd * 32 + op;
            1:       return (imm % 32) * 2048 + rs * 256 + rd * 32 + op;
            default: return imm * 256 + rd * 32 + op;
        endcase
    endfunction

    task automatic model_edge(int d);
        int full, code, w;
        full      = 1 << aw[d];
        m_done[d] = 0;
        m_we[d]   = 0;
        if (!rst_n) begin
            m_mode[d] = M_IDLE; m_ptr[d] = 0; m_cnt[d] = 0; m_err[d] = 0; m_code[d] = 0;
            m_addr[d] = 0; m_wdata[d] = 0; m_chk[d] = 0;
        end else if (m_mode[d] == M_RUN) begin
            if (in_valid) begin
                if (in_fmt == 3)                    code = 1;
                else if (in_fmt == 1 && in_imm > 31) code = 2;
                else if (m_cnt[d] == full)           code = 3;
                else                                 code = 0;
                if (code != 0) begin
                    m_mode[d] = M_ERR; m_err[d] = 1; m_code[d] = code;
                end else begin
                    w = encode(in_fmt, in_opcode, in_rd, in_rs, in_imm);
                    m_we[d] = 1; m_addr[d] = m_ptr[d]; m_wdata[d] = w;
                    m_ptr[d] = (m_ptr[d] + 1) % full;
                    m_cnt[d] = m_cnt[d] + 1;
`ifdef INST_ENC_CHECKSUM_EN
                    m_chk[d] = m_chk[d] ^ w;
`endif
                    if (in_last) begin
                        m_mode[d] = M_DONE; m_done[d] = 1;
                    end
                end
            end
        end else if (start) begin
            m_mode[d] = M_RUN; m_ptr[d] = base_addr % full; m_cnt[d] = 0;
            m_err[d] = 0; m_code[d] = 0; m_chk[d] = 0;
        end else if (m_mode[d] == M_DONE) begin
            m_mode[d] = M_IDLE;
        end
    endtask

    task automatic chk(int d, string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL d%0d.%s observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk(d, "in_ready",  d ? 32'(bus2.in_ready)  : 32'(bus8.in_ready),  32'(m_mode[d] == M_RUN));
            chk(d, "mem_we",    d ? 32'(bus2.mem_we)    : 32'(bus8.mem_we),    32'(m_we[d]));
            chk(d, "mem_addr",  d ? 32'(bus2.mem_addr)  : 32'(bus8.mem_addr),  32'(m_addr[d]));
            chk(d, "mem_wdata", d ? 32'(bus2.mem_wdata) : 32'(bus8.mem_wdata), 32'(m_wdata[d]));
            chk(d, "busy",      d ? 32'(busy2) : 32'(busy8), 32'(m_mode[d] == M_RUN));
            chk(d, "done",      d ? 32'(done2) : 32'(done8), 32'(m_done[d]));
            chk(d, "err",       d ? 32'(err2)  : 32'(err8),  32'(m_err[d]));
            chk(d, "err_code",  d ? 32'(code2) : 32'(code8), 32'(m_code[d]));
            chk(d, "word_count", d ? 32'(wc2)  : 32'(wc8),   32'(m_cnt[d]));
            chk(d, "checksum",  d ? 32'(cs2)   : 32'(cs8),   32'(m_chk[d]));
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_word(int fmt, int op, int rd, int rs, int imm, int last);
        in_valid  = 1'b1;
        in_fmt    = 2'(fmt);
        in_opcode = 5'(op);
        in_rd     = 3'(rd);
        in_rs     = 3'(rs);
        in_imm    = 8'(imm);
        in_last   = 1'(last);
    endtask

    task automatic pulse_start(int base);
        base_addr = 8'(base);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic rand_word();
        int r, fmt, imm;
        r   = $urandom_range(0, 9);
        fmt = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
        imm = $urandom_range(0, 255);
        if (fmt == 1 && $urandom_range(0, 7) != 0) imm = imm % 32;
        set_word(fmt, $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
                 imm, ($urandom_range(0, 19) == 0) ? 1 : 0);
        in_valid = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 8'h00;
        set_word(0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // test-plan program: R, I5, I8+last at base 0x10
        pulse_start(8'h10);
        set_word(0, 5'h01, 3, 5, 0, 0);
        tick();
        chk(0, "tp_wdata_r", 32'(bus8.mem_wdata), 32'h0561);
        chk(0, "tp_addr_r", 32'(bus8.mem_addr), 32'h10);
        set_word(1, 5'h0A, 1, 2, 8'h1F, 0);
        tick();
        chk(0, "tp_wdata_i5", 32'(bus8.mem_wdata), 32'hFA2A);
        set_word(2, 5'h14, 7, 0, 8'hA5, 1);
        tick();
        chk(0, "tp_wdata_i8", 32'(bus8.mem_wdata), 32'hA5F4);
        chk(0, "tp_done", 32'(done8), 32'd1);
        chk(0, "tp_count", 32'(wc8), 32'd3);
`ifdef INST_ENC_CHECKSUM_EN
        chk(0, "tp_checksum", 32'(cs8), 32'h5ABF);
`else
        chk(0, "tp_checksum", 32'(cs8), 32'h0000);
`endif
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        tick();

        // I5 immediate out of range, then restart clears the error
        pulse_start(8'h20);
        set_word(1, 3, 2, 1, 8'h20, 0);
        tick();
        chk(0, "i5_err_code", 32'(code8), 32'd2);
        in_valid = 1'b0;
        tick();
        pulse_start(8'h30);
        chk(0, "restart_err", 32'(err8), 32'd0);

        // illegal format together with last: error, no done
        set_word(3, 1, 1, 1, 0, 1);
        tick();
        chk(0, "fmt3_code", 32'(code8), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
        tick();

        // wrap and overflow on the ADDR_W=2 instance: addresses 3,0,1,2 then error 3
        pulse_start(8'h03);
        for (int i = 0; i < 5; i++) begin
            set_word(0, i + 1, i % 8, 1, 0, 0);
            tick();
            if (i < 4) chk(1, "wrap_addr", 32'(bus2.mem_addr), 32'((i + 3) % 4));
        end
        chk(1, "ovf_code", 32'(code2), 32'd3);
        chk(1, "ovf_no_we", 32'(bus2.mem_we), 32'd0);
        in_valid = 1'b0;
        tick();

        // randomized traffic with occasional start pulses
        for (int seg = 0; seg < 6; seg++) begin
            pulse_start($urandom_range(0, 255));
            for (int c = 0; c < 40; c++) begin
                rand_word();
                start = ($urandom_range(0, 15) == 0);
                base_addr = 8'($urandom_range(0, 255));
                tick();
            end
            start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
            tick();
        end

        // reset one cycle after a handshake, with another word pending
        pulse_start(8'h40);
        set_word(0, 2, 2, 2, 0, 0);
        tick();
        rst_n = 1'b0;
        tick();
        chk(0, "rst_no_we", 32'(bus8.mem_we), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Packs decoded instruction fields (opcode, rd, rs, immediate, format) into 16-bit instruction words and writes them sequentially into instruction memory. It is the encode side of the CPU's instruction format, used by the boot/program loader and by test infrastructure to fill instruction RAM. It sits between a field source with a valid/ready handshake and the instruction-memory write port. It validates each field set and reports errors.

## Interface
- ADDR_W, 8, instruction-memory address width; pointer wraps modulo 2^ADDR_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; starts a program load. Honoured only in IDLE, DONE or ERR.
- base_addr  in  ADDR_W  first write address, sampled on start.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder accepts a field set.
- in_fmt  in  2  0=R, 1=I5, 2=I8, 3=illegal.
- in_opcode  in  5  opcode, goes to word[4:0].
- in_rd  in  3  destination register, goes to word[7:5].
- in_rs  in  3  source register, goes to word[10:8]. Unused for I8.
- in_imm  in  8  immediate, unsigned.
- in_last  in  1  marks the final word of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  encoded word.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last word is written.
- err  out  1  sticky error flag.
- err_code  out  2  0=none, 1=illegal fmt, 2=I5 immediate out of range, 3=overflow.
- word_count  out  ADDR_W+1  words written since start.
- checksum  out  16  running XOR of the words written (see Configuration).

## Operation
- States: IDLE, RUN, DONE, ERR.
- IDLE → RUN on start. The pointer is loaded from base_addr, and word_count, err, err_code and checksum are cleared.
- DONE → IDLE after one cycle. A start during DONE goes directly to RUN.
- ERR → RUN on start, with the same clears as from IDLE.
- start during RUN is ignored.
- in_ready = 1 only in RUN. A handshake is in_valid & in_ready.
- Encoding per format:
  - R: {5'b0, rs, rd, opcode}.
  - I5: {imm[4:0], rs, rd, opcode}.
  - I8: {imm[7:0], rd, opcode}. rs is ignored.
- Validation is done at handshake, in priority order:
  - fmt==3 → code 1.
  - I5 with imm[7:5]≠0 → code 2.
  - word_count == 2^ADDR_W → code 3.
- On an error:
  - No write occurs and the state goes to ERR.
  - err is set and err_code is latched.
  - Outputs keep their values until start or reset.
- On a valid word:
  - The word is registered and written the next cycle.
  - The pointer increments, wrapping past 2^ADDR_W−1 to 0.
  - word_count increments.
- When in_last is accepted with a valid word, the state goes to DONE. When in_last is accepted with an invalid word, the state goes to ERR and done does not pulse.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_code=0, word_count=0, checksum=0. State is IDLE.
- Reset mid-operation aborts immediately. A pending write scheduled for the next cycle is dropped.

## Timing
- Handshake at cycle N → mem_we=1 at N+1, with mem_addr equal to the pointer value before the increment and mem_wdata equal to the encoded word.
- Throughput is one word per cycle while in_valid is held high.
- in_last accepted at N → write and done=1 both at N+1, state DONE at N+1, in_ready=0 from N+1, IDLE at N+2.
- Error at N → err=1 and err_code valid at N+1, in_ready=0 from N+1, mem_we=0 at N+1.
- A write from a word accepted at N−1 still completes at N.
- mem_we is never asserted for more than one cycle per accepted word.
- word_count and checksum update in the same cycle as mem_we.

## Configuration
- INST_ENC_CHECKSUM_EN defined: checksum equals the XOR of all mem_wdata values written since the last start, and updates with each mem_we.
- Not defined: the checksum logic is removed and checksum is tied to 16'h0000.

## Test plan
- start with base_addr=0x10, then R op=0x01 rd=3 rs=5 → mem_we at N+1, addr=0x10, wdata=0x0561, word_count=1.
- Next cycle: I5 op=0x0A rd=1 rs=2 imm=0x1F → addr=0x11, wdata=0xFA2A. Then I8 op=0x14 rd=7 imm=0xA5 with last → addr=0x12, wdata=0xA5F4, done pulse, word_count=3, checksum=0x5ABF (0 without the macro).
- I5 with imm=0x20 → no write, err=1, err_code=2, in_ready=0. A following start → RUN, err=0.
- fmt=3 asserted together with last → err_code=1, no done pulse.
- ADDR_W=2, base_addr=3: five consecutive words → addresses 3,0,1,2 written, then the fifth gives err_code=3 with no write.
- rst_n low during RUN, one cycle after a handshake → no mem_we, all outputs at reset values, state IDLE.
